// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and long-latency results queue in a FIFO.
// It keeps a per-register pending scoreboard. Define WB_LU_BYPASS_EN to let an idle port take a result with zero latency.
module reg_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [AW-1:0]     pipe_waddr,
  input  logic [DW-1:0]     pipe_wdata,
  input  logic              lu_issue,
  input  logic [AW-1:0]     lu_issue_addr,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [AW-1:0]     lu_waddr,
  input  logic [DW-1:0]     lu_wdata,
  output logic              we,
  output logic [AW-1:0]     waddr,
  output logic [DW-1:0]     wdata,
  output logic [2**AW-1:0]  pending,
  output logic              busy
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0]     fifo_addr [DEPTH];
  logic [DW-1:0]     fifo_data [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic [2**AW-1:0]  pending_q, pending_nxt;
  logic              empty, full, pop, push, bypass;

  always_comb begin
    empty    = (count == '0);
    full     = (count == (PW+1)'(DEPTH));
    pop      = !rst && !pipe_we && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    lu_ready = !rst && (!full || pop);
    bypass   = 1'b0;
`ifdef WB_LU_BYPASS_EN
    bypass   = !rst && !pipe_we && empty && lu_valid && (lu_waddr != '0);
`endif
    push     = lu_valid && lu_ready && (lu_waddr != '0) && !bypass;
    busy     = !rst && !empty;
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (pipe_we) begin
        we    = 1'b1;
        waddr = pipe_waddr;
        wdata = pipe_wdata;
      end else if (!empty) begin
        we    = 1'b1;
        waddr = fifo_addr[rptr];
        wdata = fifo_data[rptr];
      end else if (bypass) begin
        we    = 1'b1;
        waddr = lu_waddr;
        wdata = lu_wdata;
      end
    end
  end

  // Clears are applied before the set, so a new issue to the same register wins.
  always_comb begin
    pending_nxt = pending_q;
    if (pop)
      pending_nxt[fifo_addr[rptr]] = 1'b0;
    if (bypass)
      pending_nxt[lu_waddr] = 1'b0;
    if (lu_issue && (lu_issue_addr != '0))
      pending_nxt[lu_issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign pending = pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (!push && pop)
        count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= lu_waddr;
      fifo_data[wptr] <= lu_wdata;
    end
  end

  a_pipe_write_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(pipe_we && pending_q[pipe_waddr]));

endmodule
